// File: rtl/cpu_control_unit_pkg.sv
// Shared constants, FSM state and opcode encodings for the 19-bit CPU controller.
package cpu_control_unit_pkg;

    localparam int CPU_WORD_SIZE  = 19;
    localparam int CPU_ADDR_WIDTH = 19;
    localparam int TRAP_VECTOR    = 'h10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_HALT
    } ctrl_state_t;

    // Opcodes 00-0F are ALU ops (bit 3 selects logical mode); unlisted upper codes are illegal.
    typedef enum logic [4:0] {
        OPC_LOAD  = 5'h10,
        OPC_STORE = 5'h11,
        OPC_JMP   = 5'h12,
        OPC_BEQ   = 5'h13,
        OPC_BNE   = 5'h14,
        OPC_HALT  = 5'h1F
    } opcode_t;

    localparam int OPC_HI = 18;
    localparam int OPC_LO = 14;
    localparam int RD_HI  = 13;
    localparam int RD_LO  = 11;
    localparam int RS1_HI = 10;
    localparam int RS1_LO = 8;
    localparam int RS2_HI = 7;
    localparam int RS2_LO = 5;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;
    localparam int JMP_HI = 13;
    localparam int JMP_W  = 14;

    localparam logic [2:0] ALU_OP_ADD = 3'd0;
    localparam logic [2:0] ALU_OP_SUB = 3'd1;

    typedef struct packed {
        logic       mode;
        logic [2:0] op;
        logic       src_imm;
        logic       is_alu;
        logic       is_load;
        logic       is_store;
        logic       is_beq;
        logic       is_bne;
        logic       is_jmp;
        logic       is_halt;
        logic       is_illegal;
    } ctrl_word_t;

endpackage

// File: rtl/cpu_control_unit_decoder.sv
// Combinational opcode -> control word decode for the CPU controller.
module cpu_instr_decoder
    import cpu_control_unit_pkg::*;
(
    input  logic [4:0] opcode,
    output ctrl_word_t cw
);

    always_comb begin
        cw = '0;
        if (!opcode[4]) begin
            cw.is_alu = 1'b1;
            cw.mode   = opcode[3];
            cw.op     = opcode[2:0];
        end else begin
            case (opcode)
                OPC_LOAD: begin
                    cw.is_load = 1'b1;
                    cw.src_imm = 1'b1;
                    cw.op      = ALU_OP_ADD;
                end
                OPC_STORE: begin
                    cw.is_store = 1'b1;
                    cw.src_imm  = 1'b1;
                    cw.op       = ALU_OP_ADD;
                end
                OPC_JMP:  cw.is_jmp = 1'b1;
                // Branches compare rd against rs1 by subtracting and looking at zero.
                OPC_BEQ: begin
                    cw.is_beq = 1'b1;
                    cw.op     = ALU_OP_SUB;
                end
                OPC_BNE: begin
                    cw.is_bne = 1'b1;
                    cw.op     = ALU_OP_SUB;
                end
                OPC_HALT: cw.is_halt = 1'b1;
                default:  cw.is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute controller for the 19-bit CPU.
// Define ILLEGAL_OP_TRAP_EN to trap illegal opcodes to the trap vector (adds the trap port).
module cpu_control_unit
    import cpu_control_unit_pkg::*;
#(
    parameter int                    WORD_SIZE  = CPU_WORD_SIZE,
    parameter int                    ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0]  imem_rdata,
    input  logic                  imem_ack,
    output logic                  dmem_req,
    output logic                  dmem_we,
    input  logic                  dmem_ack,
    output logic                  alu_mode,
    output logic [2:0]            alu_op,
    output logic                  alu_src_imm,
    output logic [WORD_SIZE-1:0]  imm,
    output logic [2:0]            rf_raddr1,
    output logic [2:0]            rf_raddr2,
    output logic [2:0]            rf_waddr,
    output logic                  rf_we,
    output logic                  wb_sel,
    input  logic                  alu_zero,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic                  trap,
`endif
    output logic                  halted
);

    ctrl_state_t           state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt;
    logic [WORD_SIZE-1:0]  ir, ir_nxt;
    logic [ADDR_WIDTH-1:0] br_off, jmp_tgt;
    logic                  taken;
    ctrl_word_t            cw;

    cpu_instr_decoder u_dec (
        .opcode (ir[OPC_HI:OPC_LO]),
        .cw     (cw)
    );

    assign imem_addr = pc;
    assign imm       = {{(WORD_SIZE-8){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};
    assign br_off    = {{(ADDR_WIDTH-8){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};
    assign jmp_tgt   = {{(ADDR_WIDTH-JMP_W){1'b0}}, ir[JMP_HI:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        taken       = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_mode    = 1'b0;
        alu_op      = '0;
        alu_src_imm = 1'b0;
        rf_raddr1   = '0;
        rf_raddr2   = '0;
        rf_waddr    = '0;
        rf_we       = 1'b0;
        wb_sel      = 1'b0;
        halted      = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        trap        = 1'b0;
`endif

        if (state != ST_FETCH && state != ST_HALT) begin
            rf_raddr1 = ir[RS1_HI:RS1_LO];
            rf_raddr2 = (cw.is_store || cw.is_beq || cw.is_bne) ? ir[RD_HI:RD_LO]
                                                                : ir[RS2_HI:RS2_LO];
            rf_waddr  = ir[RD_HI:RD_LO];
        end

        case (state)
            ST_FETCH: begin
                // Suppressed while rst is held so reset leaves every output low.
                imem_req = !rst;
                if (imem_ack) begin
                    ir_nxt    = imem_rdata;
                    pc_nxt    = pc + ADDR_WIDTH'(1);
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: state_nxt = ST_EXECUTE;
            ST_EXECUTE: begin
                alu_mode    = cw.mode;
                alu_op      = cw.op;
                alu_src_imm = cw.src_imm;
                taken       = (cw.is_beq && alu_zero) || (cw.is_bne && !alu_zero);
                state_nxt   = ST_FETCH;
                if (cw.is_alu) begin
                    state_nxt = ST_WRITEBACK;
                end else if (cw.is_load || cw.is_store) begin
                    state_nxt = ST_MEM;
                end else if (cw.is_halt) begin
                    state_nxt = ST_HALT;
                end else if (cw.is_illegal) begin
`ifdef ILLEGAL_OP_TRAP_EN
                    pc_nxt = ADDR_WIDTH'(TRAP_VECTOR);
                    trap   = 1'b1;
`endif
                    state_nxt = ST_FETCH;
                end
                // PC already points past the branch, so the offset is relative to PC+1.
                if (taken) begin
                    pc_nxt = pc + br_off;
                end else if (cw.is_jmp) begin
                    pc_nxt = jmp_tgt;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cw.is_store;
                if (dmem_ack) begin
                    state_nxt = cw.is_load ? ST_WRITEBACK : ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                rf_we     = 1'b1;
                wb_sel    = cw.is_load;
                state_nxt = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_nxt = ST_FETCH;
        endcase
    end

endmodule
